// File: rtl/flag_writer_if.sv
// NZCV flag-producer bundle: ALU-side operands and controls in, architectural
// flags and their shadow copy out.
interface flag_writer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] ALUResult;
    logic [1:0]       ALUControl;
    logic             ShifterCarry;
    logic [1:0]       FlagW;
    logic             CondEx;
    logic             Stall;
    logic             Save;
    logic             Restore;
    logic [3:0]       Flags;
    logic [3:0]       FlagsNext;
    logic [3:0]       SavedFlags;
    logic             FlagsUpdated;

    modport master (
        output SrcA, SrcB, ALUResult, ALUControl, ShifterCarry,
        output FlagW, CondEx, Stall, Save, Restore,
        input  Flags, FlagsNext, SavedFlags, FlagsUpdated
    );

    modport slave (
        input  SrcA, SrcB, ALUResult, ALUControl, ShifterCarry,
        input  FlagW, CondEx, Stall, Save, Restore,
        output Flags, FlagsNext, SavedFlags, FlagsUpdated
    );
endinterface

// File: rtl/flag_writer.sv
// Derives NZCV from the current ALU operation and holds them in the flags
// register, with a one-entry shadow copy for exception entry and return.
module flag_writer #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'h0
) (
    input  logic          clk,
    input  logic          reset,
    flag_writer_if.slave  bus
);
    logic [3:0]   flags;
    logic [3:0]   savedFlags;
    logic [3:0]   flagsNext;
    logic         flagsUpdated;
    logic         isSub;
    logic         isArith;
    logic [WIDTH:0] sum;
    logic         n, z, c, v;
    logic         wrNZ, wrCV;

    // SUB is computed as A + ~B + 1 so C=1 means no borrow.
    always_comb begin
        isSub   = (bus.ALUControl == 2'b01);
        isArith = ~bus.ALUControl[1];
        sum     = {1'b0, bus.SrcA}
                + {1'b0, (isSub ? ~bus.SrcB : bus.SrcB)}
                + {{WIDTH{1'b0}}, isSub};
        n = bus.ALUResult[WIDTH-1];
        z = (bus.ALUResult == '0);
        if (isArith) begin
            c = sum[WIDTH];
            v = ~(bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1] ^ isSub)
              & (bus.SrcA[WIDTH-1] ^ sum[WIDTH-1]);
        end else begin
            c = bus.ShifterCarry;
            v = flags[0];
        end
    end

    // Stall beats Restore, which beats the per-group flag write.
    always_comb begin
        wrNZ      = bus.FlagW[1] & bus.CondEx;
        wrCV      = bus.FlagW[0] & bus.CondEx;
        flagsNext = flags;
        if (!bus.Stall) begin
            if (bus.Restore) begin
                flagsNext = savedFlags;
            end else begin
                if (wrNZ) flagsNext[3:2] = {n, z};
                if (wrCV) flagsNext[1:0] = {c, v};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags        <= RESET_FLAGS;
            savedFlags   <= RESET_FLAGS;
            flagsUpdated <= 1'b0;
        end else begin
            flags        <= flagsNext;
            flagsUpdated <= !bus.Stall && (flagsNext != flags);
            if (!bus.Stall && bus.Save) begin
                savedFlags <= flags;
            end
        end
    end

    assign bus.Flags        = flags;
    assign bus.FlagsNext    = flagsNext;
    assign bus.SavedFlags   = savedFlags;
    assign bus.FlagsUpdated = flagsUpdated;
endmodule

// File: tb/tb_flag_writer.sv
// Directed bench for flag_writer: a chained vector table from reset plus
// hand-written reset sequences.
module tb_flag_writer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    flag_writer_if #(.WIDTH(32)) bus ();

    flag_writer #(.WIDTH(32), .RESET_FLAGS(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        sc;
        logic [1:0]  fw;
        logic        ce;
        logic        st;
        logic        sv;
        logic        rs;
        logic [3:0]  expFlags;
        logic [3:0]  expSaved;
        logic        expUpd;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        bus.ALUControl   = t.ctl;
        bus.SrcA         = t.a;
        bus.SrcB         = t.b;
        bus.ALUResult    = t.res;
        bus.ShifterCarry = t.sc;
        bus.FlagW        = t.fw;
        bus.CondEx       = t.ce;
        bus.Stall        = t.st;
        bus.Save         = t.sv;
        bus.Restore      = t.rs;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Each row follows from the state left by the previous one.
        //         name        ctl    a             b             res           sc    fw     ce    st    sv    rs    flags    saved    upd
        vecs[0]  = '{"sub55",   2'b01, 32'd5,        32'd5,        32'd0,        1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b1};
        vecs[1]  = '{"sub55rep",2'b01, 32'd5,        32'd5,        32'd0,        1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0};
        vecs[2]  = '{"addovf",  2'b00, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1};
        vecs[3]  = '{"orr0",    2'b11, 32'd0,        32'd0,        32'd0,        1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0000, 1'b1};
        vecs[4]  = '{"sub31nz", 2'b01, 32'd3,        32'd1,        32'd2,        1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000, 1'b1};
        vecs[5]  = '{"condex0", 2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000, 1'b0};
        vecs[6]  = '{"sub13cv", 2'b01, 32'd1,        32'd3,        32'hFFFFFFFE, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[7]  = '{"addneg",  2'b00, 32'h80000000, 32'd0,        32'h80000000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1};
        vecs[8]  = '{"save",    2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0};
        vecs[9]  = '{"addzero", 2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1000, 1'b1};
        vecs[10] = '{"restore", 2'b00, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1};
        vecs[11] = '{"addzero2",2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1000, 1'b1};
        vecs[12] = '{"swap",    2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b0100, 1'b1};
        vecs[13] = '{"stall",   2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b0100, 1'b0};
        vecs[14] = '{"rsnocond",2'b00, 32'd0,        32'd0,        32'd0,        1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1};
        vecs[15] = '{"subovf",  2'b01, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0100, 1'b1};
        vecs[16] = '{"andneg",  2'b10, 32'hF0000000, 32'hFFFFFFFF, 32'hF0000000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0100, 1'b1};
        vecs[17] = '{"idle",    2'b10, 32'd0,        32'd0,        32'd1,        1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0100, 1'b0};

        applyStimulus('{"init", 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0});
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetFlags", bus.Flags, 4'h0);
        checkOutput("resetSaved", bus.SavedFlags, 4'h0);
        checkOutput("resetUpd", {3'b000, bus.FlagsUpdated}, 4'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".next"}, bus.FlagsNext, vecs[i].expFlags);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, ".flags"}, bus.Flags, vecs[i].expFlags);
            checkOutput({vecs[i].name, ".saved"}, bus.SavedFlags, vecs[i].expSaved);
            checkOutput({vecs[i].name, ".upd"}, {3'b000, bus.FlagsUpdated}, {3'b000, vecs[i].expUpd});
        end

        // Async reset in mid-cycle while Save and Restore are both pending.
        @(negedge clk);
        applyStimulus('{"midrst", 2'b01, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstFlags", bus.Flags, 4'h0);
        checkOutput("midRstSaved", bus.SavedFlags, 4'h0);
        checkOutput("midRstUpd", {3'b000, bus.FlagsUpdated}, 4'h0);
        @(negedge clk);
        applyStimulus('{"quiet", 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0});
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstFlags", bus.Flags, 4'h0);
        checkOutput("postRstUpd", {3'b000, bus.FlagsUpdated}, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
